// File: rtl/jk_bank_driver_if.sv
// Request/drive/feedback bundle between a requester, jk_bank_driver and an external JK flop bank.
interface jk_bank_driver_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             ack;
  logic             err;

  modport master (
    output req, target, q_fb,
    input  j, k, busy, ack, err
  );

  modport slave (
    input  req, target, q_fb,
    output j, k, busy, ack, err
  );
endinterface

// File: rtl/jk_bank_driver.sv
// Drives a bank of external JK flops to a requested value, checking the fed-back Q and
// re-driving up to MAX_RETRY times before flagging an error.
module jk_bank_driver #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TOGGLE_MODE = 0
) (
  input logic               clk,
  input logic               rst_n,
  jk_bank_driver_if.slave   bus
);

  localparam int unsigned CntW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_RETRY);

  typedef enum logic [2:0] {StIdle, StCalc, StApply, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [CntW-1:0]  retry_q, retry_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] exc_j, exc_k;

  // Excitation: bits already at target always get j=k=0 (hold) in both modes.
  if (TOGGLE_MODE != 0) begin : g_toggle
    assign exc_j = bus.q_fb ^ tgt_q;
    assign exc_k = bus.q_fb ^ tgt_q;
  end else begin : g_setreset
    assign exc_j = ~bus.q_fb & tgt_q;
    assign exc_k = bus.q_fb & ~tgt_q;
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    retry_d = retry_q;
    err_d   = err_q;
    j_d     = '0;
    k_d     = '0;
    ack_d   = 1'b0;
    busy_d  = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (bus.req) begin
          tgt_d   = bus.target;
          retry_d = '0;
          err_d   = 1'b0;
          state_d = StCalc;
          busy_d  = 1'b1;
        end
      end
      StCalc: begin
        j_d     = exc_j;
        k_d     = exc_k;
        state_d = StApply;
      end
      StApply: begin
        state_d = StCheck;
      end
      StCheck: begin
        if (bus.q_fb == tgt_q) begin
          state_d = StDone;
          ack_d   = 1'b1;
        end else if (retry_q < MaxCnt) begin
          retry_d = retry_q + CntW'(1);
          state_d = StCalc;
        end else begin
          err_d   = 1'b1;
          state_d = StDone;
          ack_d   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tgt_q   <= '0;
      retry_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      retry_q <= retry_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign bus.j    = j_q;
  assign bus.k    = k_q;
  assign bus.busy = busy_q;
  assign bus.ack  = ack_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: two instances (set/reset and toggle excitation), each driving a
// behavioural JK flop bank; table-driven transactions plus retry, req-hold and reset sequences.
module tb_jk_bank_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       req_drv = 1'b0;
  logic [3:0] target_drv = '0;
  logic [3:0] stuck0 = '0;
  logic [3:0] bank0_q, bank1_q;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jk_bank_driver_if #(.WIDTH(4)) bus0 ();
  jk_bank_driver_if #(.WIDTH(4)) bus1 ();

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(3), .TOGGLE_MODE(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(3), .TOGGLE_MODE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  assign bus0.req    = req_drv & ~sel;
  assign bus1.req    = req_drv & sel;
  assign bus0.target = target_drv;
  assign bus1.target = target_drv;
  assign bus0.q_fb   = bank0_q & ~stuck0;
  assign bus1.q_fb   = bank1_q;

  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] j,
                                         input logic [3:0] k);
    return (j & ~q) | (~k & q);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0_q <= '0;
      bank1_q <= '0;
    end else begin
      bank0_q <= jk_next(bank0_q, bus0.j, bus0.k);
      bank1_q <= jk_next(bank1_q, bus1.j, bus1.k);
    end
  end

  logic [3:0] obs_j, obs_k, obs_q;
  logic       obs_busy, obs_ack, obs_err;
  always_comb begin
    obs_j    = sel ? bus1.j    : bus0.j;
    obs_k    = sel ? bus1.k    : bus0.k;
    obs_q    = sel ? bus1.q_fb : bus0.q_fb;
    obs_busy = sel ? bus1.busy : bus0.busy;
    obs_ack  = sel ? bus1.ack  : bus0.ack;
    obs_err  = sel ? bus1.err  : bus0.err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_j0"}, 32'(bus0.j), 32'h0);
    check({name, "_k0"}, 32'(bus0.k), 32'h0);
    check({name, "_busy0"}, 32'(bus0.busy), 32'h0);
    check({name, "_ack0"}, 32'(bus0.ack), 32'h0);
    check({name, "_err0"}, 32'(bus0.err), 32'h0);
    check({name, "_j1"}, 32'(bus1.j), 32'h0);
    check({name, "_busy1"}, 32'(bus1.busy), 32'h0);
  endtask

  // One request on the selected instance; samples #1 after each posedge following acceptance.
  task automatic run_txn(input string name, input logic [3:0] t, input logic [3:0] exp_j,
                         input logic [3:0] exp_k, input logic [3:0] exp_q, input int exp_n,
                         input logic exp_err, input int exp_pulses);
    int first_ack = -1;
    int pulses = 0;
    @(negedge clk);
    req_drv    = 1'b1;
    target_drv = t;
    @(posedge clk);
    #1;
    req_drv = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        check({name, "_apply_j"}, 32'(obs_j), 32'(exp_j));
        check({name, "_apply_k"}, 32'(obs_k), 32'(exp_k));
        check({name, "_busy"}, 32'(obs_busy), 32'h1);
      end
      if (obs_j != 4'h0 || obs_k != 4'h0) pulses++;
      if (obs_ack && first_ack < 0) begin
        first_ack = n;
        check({name, "_err_at_ack"}, 32'(obs_err), 32'(exp_err));
      end
      if (first_ack > 0 && n == first_ack + 1) begin
        check({name, "_ack_one_cycle"}, 32'(obs_ack), 32'h0);
        check({name, "_idle_busy"}, 32'(obs_busy), 32'h0);
        break;
      end
    end
    check({name, "_ack_cycle"}, 32'(first_ack), 32'(exp_n));
    check({name, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    check({name, "_q_fb"}, 32'(obs_q), 32'(exp_q));
  endtask

  typedef struct {
    string      name;
    logic       mode;
    logic [3:0] tgt;
    logic [3:0] exp_j;
    logic [3:0] exp_k;
    logic [3:0] exp_q;
    int         pulses;
  } vec_t;

  vec_t vecs[7];
  int   acks;

  initial begin
    vecs[0] = '{"m0_0000_to_1010", 1'b0, 4'b1010, 4'b1010, 4'b0000, 4'b1010, 1};
    vecs[1] = '{"m0_1010_to_0110", 1'b0, 4'b0110, 4'b0100, 4'b1000, 4'b0110, 1};
    vecs[2] = '{"m0_same_target",  1'b0, 4'b0110, 4'b0000, 4'b0000, 4'b0110, 0};
    vecs[3] = '{"m0_0110_to_0000", 1'b0, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 1};
    vecs[4] = '{"m1_0000_to_0110", 1'b1, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 1};
    vecs[5] = '{"m1_0110_to_1001", 1'b1, 4'b1001, 4'b1111, 4'b1111, 4'b1001, 1};
    vecs[6] = '{"m1_same_target",  1'b1, 4'b1001, 4'b0000, 4'b0000, 4'b1001, 0};

    // Reset is asserted from time 0: outputs must already be low before any clock edge.
    #2;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      sel = vecs[i].mode;
      run_txn(vecs[i].name, vecs[i].tgt, vecs[i].exp_j, vecs[i].exp_k, vecs[i].exp_q,
              3, 1'b0, vecs[i].pulses);
    end

    // Bit 0 stuck low: four attempts, then err with ack; err persists while idle.
    sel    = 1'b0;
    stuck0 = 4'b0001;
    run_txn("stuck", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 12, 1'b1, 4);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("stuck_err_held", 32'(bus0.err), 32'h1);
    end
    stuck0 = 4'b0000;
    run_txn("after_stuck", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 3, 1'b0, 0);

    // req held 10 cycles with target toggling: captures at the two IDLE acceptances only.
    acks = 0;
    @(negedge clk);
    for (int n = 0; n < 15; n++) begin
      req_drv    = (n < 10);
      target_drv = (n % 2 == 0) ? 4'b1100 : 4'b0011;
      @(posedge clk);
      #1;
      if (bus0.ack) acks++;
      if (n == 3) check("hold_first_capture", 32'(bus0.q_fb), 32'h0000_000c);
    end
    req_drv = 1'b0;
    check("hold_ack_count", 32'(acks), 32'h2);
    check("hold_final_q", 32'(bus0.q_fb), 32'h0000_0003);

    // Reset pulse during APPLY aborts without ack.
    @(negedge clk);
    req_drv    = 1'b1;
    target_drv = 4'b1111;
    @(posedge clk);
    #1;
    req_drv = 1'b0;
    @(posedge clk);
    #1;
    check("abort_apply_j", 32'(bus0.j), 32'h0000_000c);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    acks  = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (bus0.ack) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'h0);
    check("abort_busy", 32'(bus0.busy), 32'h0);

    // First request after reset is accepted normally.
    run_txn("post_reset", 4'b0101, 4'b0101, 4'b0000, 4'b0101, 3, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
